// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions, skid state encoding and the bitwise result function
// for the registered logic unit.
package logic_unit_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned MAX_W = 64;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    // Encoding mirrors {skid_v, out_v}
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_FULL1 = 2'b01,
        SKID_FULL2 = 2'b11
    } skid_state_e;

    // Bits above width are forced to zero so callers may truncate freely
    function automatic logic [MAX_W-1:0] lu_eval(
        input logic [OP_W-1:0]  op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      width
    );
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] mask;
        if (width >= MAX_W) begin
            mask = '1;
        end else begin
            mask = (MAX_W'(1) << width) - MAX_W'(1);
        end
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = ~a;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/logic_unit_skid.sv
// Generic two-entry skid buffer: an output register plus one skid register,
// with a registered ready that never depends combinationally on ready_i.
module logic_unit_skid
    import logic_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              xfer;

    // State and storage registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and storage steering
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        accept  = valid_i && ready_q;
        xfer    = (state_q != SKID_EMPTY) && ready_i;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_d   = data_i;
                    state_d = SKID_FULL1;
                end
            end
            SKID_FULL1: begin
                if (accept && !xfer) begin
                    skid_d  = data_i;
                    state_d = SKID_FULL2;
                end else if (accept && xfer) begin
                    out_d   = data_i;
                end else if (xfer) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL2: begin
                if (xfer) begin
                    out_d   = skid_q;
                    state_d = SKID_FULL1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        ready_d = (state_d != SKID_FULL2);
    end

    assign ready_o = ready_q;
    assign data_o  = out_q;
    assign valid_o = (state_q != SKID_EMPTY);

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: op decode and flag reduction feed a two-entry
// skid buffer; a wrapping counter tallies accepted transactions.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [OP_W-1:0]  op_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] y_out,
    output logic             zero_out,
    output logic             ones_out,
    output logic             parity_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [CNT_W-1:0] count_out
);

    localparam int unsigned DATA_W = WIDTH + 3;

    logic [WIDTH-1:0]  result_c;
    logic [DATA_W-1:0] payload_c;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept_c;

    // Flags travel with the result so they stay aligned under back-pressure
    always_comb begin
        result_c  = WIDTH'(lu_eval(op_in, MAX_W'(a_in), MAX_W'(b_in), WIDTH));
        payload_c = {^result_c, &result_c, (result_c == '0), result_c};
    end

    logic_unit_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .data_i  (payload_c),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_o  (out_data),
        .valid_o (valid_out),
        .ready_i (ready_in)
    );

    // Accepted-transaction counter, wraps naturally
    assign accept_c = valid_in && ready_out;

    always_comb begin
        count_d = count_q;
        if (accept_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign y_out      = out_data[WIDTH-1:0];
    assign zero_out   = out_data[WIDTH];
    assign ones_out   = out_data[WIDTH+1];
    assign parity_out = out_data[WIDTH+2];
    assign count_out  = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized bench for logic_unit_pipe against a queue-based
// reference model of the two-deep result buffer.
module tb_logic_unit_pipe;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [2:0] op_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b0;

    logic        ready_out, valid_out, zero_out, ones_out, parity_out;
    logic [7:0]  y_out;
    logic [15:0] count_out;

    logic        ready4, valid4, zero4, ones4, parity4;
    logic [7:0]  y4;
    logic [3:0]  count4;

    int checks = 0;
    int errors = 0;

    // Model: FIFO of {parity, ones, zero, y}, capacity 2
    logic [10:0] mq[$];
    logic        m_ready = 1'b1;
    int          m_count = 0;
    int          m_accepts = 0;
    int          dut_xfers = 0;
    logic        last_rst = 1'b1;

    logic [7:0] exp_sweep[8];

    always #5 clk_in = ~clk_in;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .valid_in(valid_in), .ready_out(ready_out), .y_out(y_out), .zero_out(zero_out),
        .ones_out(ones_out), .parity_out(parity_out), .valid_out(valid_out),
        .ready_in(ready_in), .count_out(count_out)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk_in(clk_in), .rst_in(rst_in), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .valid_in(valid_in), .ready_out(ready4), .y_out(y4), .zero_out(zero4),
        .ones_out(ones4), .parity_out(parity4), .valid_out(valid4),
        .ready_in(ready_in), .count_out(count4)
    );

    function automatic logic [10:0] ref_eval(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [7:0] y;
        case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = ~a;
            3'd3: y = a ^ b;
            3'd4: y = ~(a & b);
            3'd5: y = ~(a | b);
            3'd6: y = ~(a ^ b);
            default: y = a;
        endcase
        return {^y, (y == 8'hFF), (y == 8'h00), y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_out", 32'(valid_out), 32'(mq.size() > 0));
        chk("ready_out", 32'(ready_out), 32'(m_ready));
        chk("count_out", 32'(count_out), 32'(m_count % 65536));
        chk("count4", 32'(count4), 32'(m_count % 16));
        chk("valid4", 32'(valid4), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("y_out", 32'(y_out), 32'(mq[0][7:0]));
            chk("zero_out", 32'(zero_out), 32'(mq[0][8]));
            chk("ones_out", 32'(ones_out), 32'(mq[0][9]));
            chk("parity_out", 32'(parity_out), 32'(mq[0][10]));
        end else if (last_rst) begin
            chk("rst_y", 32'(y_out), 32'd0);
            chk("rst_flags", 32'({parity_out, ones_out, zero_out}), 32'd0);
        end
    endtask

    // One clock: drive inputs, advance the model, then check just after the edge
    task automatic cycle(input logic rst, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op, input logic rdy,
                         output logic acc);
        logic xfer;
        rst_in = rst; valid_in = v; a_in = a; b_in = b; op_in = op; ready_in = rdy;
        #1;
        if (!rst && valid_out && ready_in) dut_xfers++;
        if (rst) begin
            mq.delete();
            m_ready = 1'b1;
            m_count = 0;
            acc = 1'b0;
        end else begin
            acc  = v && m_ready;
            xfer = (mq.size() > 0) && rdy;
            if (xfer) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(ref_eval(op, a, b));
                m_count++;
                m_accepts++;
            end
            m_ready = (mq.size() < 2);
        end
        last_rst = rst;
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    // Keep offering one beat until the model says it was accepted
    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic rdy);
        logic acc;
        int   tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            cycle(1'b0, 1'b1, a, b, op, rdy, acc);
            tries++;
        end
        if (!acc) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic acc;
        exp_sweep = '{8'h05, 8'hAF, 8'h5A, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};

        // Reset state
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc);

        // Ops sweep at full throughput
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'hA5, 8'h0F, 3'(i), 1'b1, acc);
            chk($sformatf("sweep_op%0d", i), 32'(y_out), 32'(exp_sweep[i]));
        end

        // Flag corners
        cycle(1'b0, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b1, acc);
        chk("and_flags", 32'({zero_out, ones_out, parity_out}), 32'b100);
        cycle(1'b0, 1'b1, 8'hFF, 8'h00, 3'd1, 1'b1, acc);
        chk("or_ones", 32'({y_out, ones_out}), 32'({8'hFF, 1'b1}));
        cycle(1'b0, 1'b1, 8'h01, 8'h00, 3'd3, 1'b1, acc);
        chk("xor_parity", 32'(parity_out), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

        // Back-pressure: 4 beats, ready_in drops after the first transfer
        dut_xfers = 0;
        m_accepts = 0;
        offer(8'h11, 8'h22, 3'd3, 1'b1);
        offer(8'h33, 8'h44, 3'd1, 1'b1);
        offer(8'h55, 8'h0F, 3'd0, 1'b0);
        chk("bp_ready_low", 32'(ready_out), 32'd0);
        // Hold: beat 4 is offered but blocked while outputs must stay put
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'h77, 8'h88, 3'd6, 1'b0, acc);
            chk("hold_y", 32'(y_out), 32'(ref_eval(3'd1, 8'h33, 8'h44) & 11'hFF));
        end
        offer(8'h77, 8'h88, 3'd6, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
        chk("bp_no_loss", 32'(dut_xfers), 32'(m_accepts));

        // Counter wrap on the 4-bit instance
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'(i), 8'hC3, 3'(i), 1'b1, acc);
        chk("wrap_count4", 32'(count4), 32'd1);
        chk("wrap_count16", 32'(count_out), 32'd17);

        // Reset from FULL2
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
        cycle(1'b0, 1'b1, 8'h3C, 8'hF0, 3'd0, 1'b0, acc);
        cycle(1'b0, 1'b1, 8'h3C, 8'hF0, 3'd4, 1'b0, acc);
        chk("full2_ready", 32'(ready_out), 32'd0);
        cycle(1'b1, 1'b1, 8'h3C, 8'hF0, 3'd4, 1'b1, acc);
        chk("rst_mid", 32'({valid_out, ready_out, count_out}), 32'({1'b0, 1'b1, 16'd0}));
        cycle(1'b0, 1'b1, 8'h3C, 8'hF0, 3'd5, 1'b0, acc);
        chk("post_rst_y", 32'(y_out), 32'h03);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
